// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: eight-source round-robin arbiter with a registered one-hot grant and a valid/ready handshake
module onehot_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int PTR_RST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [WIDTH-1:0] pending,
    output logic             busy
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state;
    logic [2:0] ptr, gidx, win, idx;
    logic       hs;

    assign hs          = grant_valid & grant_ready;
    assign grant_valid = state == GRANT;
    assign busy        = |pending | grant_valid;

    // Scan from the far end back toward ptr so the closest pending source wins.
    always_comb begin
        win = ptr;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (pending[idx]) win = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            grant   <= '0;
            gidx    <= '0;
            ptr     <= 3'(PTR_RST);
        end else begin
            pending <= (pending & ~(hs ? grant : '0)) | req;
            if (state == IDLE && |pending) begin
                state <= GRANT;
                grant <= WIDTH'(1) << win;
                gidx  <= win;
            end else if (hs) begin
                state <= IDLE;
                grant <= '0;
                ptr   <= gidx + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// tb_onehot_rr_arbiter: directed and randomized checks against a behavioural arbiter model
module tb_onehot_rr_arbiter;
    logic       clk = 0;
    logic       rst_n = 0;
    logic [7:0] req = 0;
    logic       grant_ready = 0;
    logic [7:0] grant, pending;
    logic       grant_valid, busy;
    int         n_checks = 0;
    int         n_fail = 0;

    bit   [7:0] m_pend;
    bit         m_valid;
    int         m_w, m_ptr;

    onehot_rr_arbiter #(.WIDTH(8), .PTR_RST(0)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .grant_valid(grant_valid),
        .grant_ready(grant_ready), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, written from the arbitration rules.
    task automatic model_edge();
        bit [7:0] nxt;
        if (!rst_n) begin
            m_pend = 0; m_valid = 0; m_w = 0; m_ptr = 0;
        end else begin
            nxt = m_pend;
            if (m_valid && grant_ready) nxt[m_w] = 0;
            nxt |= req;
            if (!m_valid) begin
                if (m_pend != 0) begin
                    for (int k = 7; k >= 0; k--)
                        if (m_pend[(m_ptr + k) % 8]) m_w = (m_ptr + k) % 8;
                    m_valid = 1;
                end
            end else if (grant_ready) begin
                m_valid = 0;
                m_ptr = (m_w + 1) % 8;
            end
            m_pend = nxt;
        end
    endtask

    task automatic tick(input logic [7:0] r, input logic rdy, input logic rn);
        logic [7:0] eg;
        req = r; grant_ready = rdy; rst_n = rn;
        @(posedge clk);
        model_edge();
        #1;
        eg = m_valid ? 8'(1 << m_w) : 8'h00;
        check("grant", grant, eg);
        check("grant_valid", {7'b0, grant_valid}, {7'b0, m_valid});
        check("pending", pending, m_pend);
        check("busy", {7'b0, busy}, {7'b0, (m_pend != 0) || m_valid});
        check("onehot0", {7'b0, $onehot0(grant)}, 8'h01);
    endtask

    initial begin
        tick(0, 0, 0); tick(0, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 0, 1);
        check("idle_grant", grant, 8'h00);
        check("idle_busy", {7'b0, busy}, 8'h00);

        tick(8'h20, 1, 1); tick(0, 1, 1);
        check("single_grant", grant, 8'h20);
        tick(0, 1, 1);
        check("single_pend", pending, 8'h00);
        check("single_busy", {7'b0, busy}, 8'h00);

        tick(0, 0, 0); tick(8'hFF, 1, 1);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 1);
            check("rotate", grant, 8'(1 << i));
            tick(0, 1, 1);
        end
        check("rotate_done", pending, 8'h00);

        tick(0, 0, 0); tick(8'h06, 0, 1);
        for (int i = 0; i < 6; i++) begin
            tick(i == 2 ? 8'h01 : 8'h00, 0, 1);
            check("hold", grant, 8'h02);
        end
        tick(0, 1, 1); tick(0, 1, 1);
        check("bp_next", grant, 8'h04);
        tick(0, 1, 1); tick(0, 1, 1);
        check("bp_last", grant, 8'h01);
        tick(0, 1, 1);

        tick(0, 0, 0); tick(8'h0A, 0, 1); tick(0, 0, 1); tick(0, 1, 1); tick(0, 0, 1);
        check("sc_grant", grant, 8'h08);
        tick(8'h28, 1, 1);
        check("sc_pend", pending, 8'h28);
        tick(0, 1, 1);
        check("sc_order", grant, 8'h20);
        tick(0, 1, 1); tick(0, 1, 1);
        check("sc_regrant", grant, 8'h08);
        tick(0, 1, 1);

        tick(0, 0, 0); tick(8'h08, 1, 1); tick(0, 1, 1); tick(0, 1, 1);
        tick(8'h31, 0, 1); tick(0, 0, 1);
        check("mid_grant", grant, 8'h10);
        check("mid_pend", pending, 8'h31);
        tick(0, 0, 0);
        check("rst_grant", grant, 8'h00);
        check("rst_pend", pending, 8'h00);
        tick(8'h80, 1, 1); tick(0, 1, 1);
        check("post_rst80", grant, 8'h80);
        tick(0, 1, 1);
        tick(0, 0, 0); tick(8'h81, 1, 1); tick(0, 1, 1);
        check("post_rst_ptr", grant, 8'h01);

        for (int i = 0; i < 400; i++)
            tick(8'($urandom & $urandom & $urandom), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 63) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/onehot_rr_arbiter.md
Name: onehot_rr_arbiter

Overview:
- Eight-source round-robin request arbiter that sits directly upstream of the 8-to-3 encoder.
- Latches incoming request pulses into a pending register and picks one pending source per transaction.
- Presents the winner as a registered one-hot grant that drives the encoder's 8-bit input, so the encoder output is the index of the served source.
- Uses a valid/ready handshake toward the consumer of the encoded index.

Parameters:
- WIDTH, 8, number of request sources; fixed at 8 to match the encoder input width (other values unsupported).
- PTR_RST, 0, source index given highest priority after reset (0..7).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req  input  8  request lines; any bit high in a cycle sets the matching pending bit.
- grant  output  8  registered one-hot grant; all zeros when grant_valid=0.
- grant_valid  output  1  grant holds a valid one-hot winner.
- grant_ready  input  1  consumer accepts the grant when grant_valid & grant_ready at the clock edge.
- pending  output  8  current pending-request register (debug/status).
- busy  output  1  high when pending != 0 or grant_valid=1.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pending=0, grant=0, grant_valid=0, busy=0.
  - Priority pointer ptr=PTR_RST; state=IDLE.
  - Reset overrides everything, including a grant in progress and a concurrent req; no grant survives reset.
- Pending register:
  - Each cycle, pending_next = (pending & ~clr) | req.
  - clr is the one-hot grant when a handshake completes that cycle, else 0.
  - Set wins: if req[k]=1 in the same cycle grant[k] is accepted, pending[k] stays 1 and source k is served again later.
  - Repeated req on a bit that is already pending is absorbed; there is no counting.
- State machine with two states, IDLE and GRANT:
  - IDLE: if pending != 0, select winner w = first set bit of pending searching ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8). Register grant=1<<w, grant_valid=1, go to GRANT. If pending=0, stay in IDLE with grant=0.
  - GRANT: grant and grant_valid are held stable until grant_ready=1. The winner never changes while waiting, even if higher-priority requests arrive.
  - On handshake: clear pending[w], set ptr=(w+1) mod 8, grant=0, grant_valid=0, return to IDLE.
- Latency:
  - req[k] high in cycle N (with idle arbiter, empty pending) -> pending[k]=1 after edge N -> grant_valid=1 after edge N+1. That is two cycles from req to grant.
  - After a handshake there is exactly one IDLE cycle (grant_valid=0) before the next grant. Maximum throughput is one grant per 2 cycles.
- Fairness: with all 8 bits continuously pending and grant_ready tied high, grants rotate w, w+1, ..., each source served once per 8 grants.
- Invariants:
  - grant is zero or exactly one-hot, never multi-hot.
  - grant_valid=1 implies pending[w]=1.
  - busy = |pending | grant_valid (combinational from registers).
- grant_ready while grant_valid=0 is ignored.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, req=0 -> grant=8'h00, grant_valid=0, pending=8'h00, busy=0 for 10 cycles.
- Single request latency: one-cycle pulse req=8'b0010_0000 at cycle N, grant_ready=1 -> grant=8'b0010_0000 and grant_valid=1 after edge N+1 (encoder y=3'b101). Accepted at edge N+2, then pending=0 and busy=0.
- Round-robin rotation: pulse req=8'hFF once, grant_ready=1, PTR_RST=0 -> grants 01,02,04,08,10,20,40,80 on every other cycle (encoder y=0..7), then idle.
- Backpressure hold: pending=8'b0000_0110, grant_ready=0 for 5 cycles -> grant=8'b0000_0010 held stable; pulse req=8'h01 meanwhile does not change grant. Raising ready yields next grant 8'b0000_0100, then 8'b0000_0001.
- Simultaneous set/clear: req[3]=1 in the same cycle grant=8'h08 is accepted -> pending[3] remains 1. Source 3 is re-granted only after the other pending sources above it in rotation order.
- Reset mid-grant: grant_valid=1, grant=8'h10, pending=8'h31, assert rst_n=0 one cycle -> next cycle grant=0, grant_valid=0, pending=0. The next req=8'h80 pulse is granted with ptr back at PTR_RST.
